// File: rtl/qmult_pkg.sv
// Shared fixed-point defaults and helpers for the round-robin Q-format multiplier.
package qmult_pkg;

  localparam int N_DEF    = 16;
  localparam int Q_DEF    = 8;
  localparam int NREQ_DEF = 4;

  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Magnitude of a sign-extended value; the most-negative N-bit input yields 2^(N-1).
  function automatic logic [31:0] fx_abs(input logic signed [31:0] v);
    return (v < 0) ? 32'(-v) : 32'(v);
  endfunction

  function automatic logic [31:0] sat_pos(input int n);
    return (32'd1 << (n - 1)) - 32'd1;
  endfunction

  // Two's complement pattern of -(2^(n-1)-1) within n bits.
  function automatic logic [31:0] sat_neg(input int n);
    return (32'd1 << (n - 1)) + 32'd1;
  endfunction

endpackage

// File: rtl/qmult_core.sv
// Combinational sign-magnitude Q-format multiply with overflow flag.
// Saturates on overflow when QMULT_RR_SCHED_SAT_EN is defined.
module qmult_core
  import qmult_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int Q = Q_DEF
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_data,
  output logic         o_ovr
);

  localparam logic [N-1:0] SAT_P = N'(sat_pos(N));
  localparam logic [N-1:0] SAT_N = N'(sat_neg(N));

  logic [31:0]    abs_a, abs_b;
  logic [N-1:0]   mag_a, mag_b, mag, wrapped;
  logic [2*N-1:0] prod;
  logic           neg;
  logic           unused_bits;

  assign abs_a = fx_abs(32'(signed'(i_a)));
  assign abs_b = fx_abs(32'(signed'(i_b)));
  assign mag_a = abs_a[N-1:0];
  assign mag_b = abs_b[N-1:0];

  assign prod    = {{N{1'b0}}, mag_a} * {{N{1'b0}}, mag_b};
  assign mag     = {1'b0, prod[N-2+Q:Q]};
  assign o_ovr   = |prod[2*N-2:N-1+Q];
  assign neg     = i_a[N-1] ^ i_b[N-1];
  assign wrapped = neg ? -mag : mag;

  // Truncated fraction bits and the top product bit never contribute.
  assign unused_bits = ^{abs_a[31:N], abs_b[31:N], prod[2*N-1], prod[Q-1:0]};

  always_comb begin
`ifdef QMULT_RR_SCHED_SAT_EN
    o_data = o_ovr ? (neg ? SAT_N : SAT_P) : wrapped;
`else
    o_data = wrapped;
`endif
  end

endmodule

// File: rtl/qmult_rr_sched.sv
// Round-robin scheduler feeding one 2-stage pipelined Q-format multiplier.
// Optional output saturation via QMULT_RR_SCHED_SAT_EN (handled in qmult_core).
module qmult_rr_sched
  import qmult_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int Q    = Q_DEF,
  parameter int NREQ = NREQ_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NREQ-1:0]            i_req_valid,
  output logic [NREQ-1:0]            o_req_ready,
  input  logic [NREQ*N-1:0]          i_req_a,
  input  logic [NREQ*N-1:0]          i_req_b,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [id_width(NREQ)-1:0]  o_rsp_id,
  output logic [N-1:0]               o_rsp_data,
  output logic                       o_rsp_ovr
);

  localparam int IDW    = id_width(NREQ);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
  } s1_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [N-1:0]   data;
    logic           ovr;
  } rsp_t;

  logic [NREQ-1:0][N-1:0] req_a, req_b;

  for (genvar k = 0; k < NREQ; k++) begin : g_lane
    assign req_a[k] = i_req_a[k*N +: N];
    assign req_b[k] = i_req_b[k*N +: N];
  end

  logic [STAGES:1] vld_pipe_d, vld_pipe_q;
  logic [IDW-1:0]  ptr_d, ptr_q;
  s1_t             s1_d, s1_q;
  rsp_t            rsp_d, rsp_q;

  logic            adv1, adv2, accept, gnt_any;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] gnt_oh;
  logic [N-1:0]    core_data;
  logic            core_ovr;
  int              idx;

  assign adv2 = ~vld_pipe_q[2] | i_rsp_ready;
  assign adv1 = ~vld_pipe_q[1] | adv2;

  // First valid requester strictly after the pointer, wrapping around.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!gnt_any && i_req_valid[idx[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = idx[IDW-1:0];
      end
    end
  end

  // Nothing is accepted while reset is held, so no entry survives it.
  assign accept      = gnt_any & adv1 & ~i_rst;
  assign gnt_oh      = gnt_any ? (NREQ'(1) << gnt_id) : '0;
  assign o_req_ready = gnt_oh & {NREQ{adv1 & ~i_rst}};

  qmult_core #(.N(N), .Q(Q)) u_core (
    .i_a    (s1_q.a),
    .i_b    (s1_q.b),
    .o_data (core_data),
    .o_ovr  (core_ovr)
  );

  always_comb begin
    ptr_d      = accept ? gnt_id : ptr_q;
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    rsp_d      = rsp_q;
    if (adv1) begin
      vld_pipe_d[1] = accept;
      if (accept) s1_d = '{id: gnt_id, a: req_a[gnt_id], b: req_b[gnt_id]};
    end
    if (adv2) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (vld_pipe_q[1]) rsp_d = '{id: s1_q.id, data: core_data, ovr: core_ovr};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q      <= IDW'(NREQ - 1);
      vld_pipe_q <= '0;
      s1_q       <= '0;
      rsp_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      rsp_q      <= rsp_d;
    end
  end

  assign o_rsp_valid = vld_pipe_q[2];
  assign o_rsp_id    = rsp_q.id;
  assign o_rsp_data  = rsp_q.data;
  assign o_rsp_ovr   = rsp_q.ovr;

endmodule

// File: tb/tb_qmult_rr_sched.sv
// Directed self-checking bench for qmult_rr_sched (N=16, Q=8, NREQ=4).
module tb_qmult_rr_sched;

  localparam int N    = 16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

`ifdef QMULT_RR_SCHED_SAT_EN
  localparam logic [15:0] OVP = 16'h7FFF;
  localparam logic [15:0] OVN = 16'h8001;
`else
  localparam logic [15:0] OVP = 16'h0000;
  localparam logic [15:0] OVN = 16'h0000;
`endif

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [NREQ-1:0]   i_req_valid;
  logic [NREQ-1:0]   o_req_ready;
  logic [NREQ*N-1:0] i_req_a;
  logic [NREQ*N-1:0] i_req_b;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [IDW-1:0]    o_rsp_id;
  logic [N-1:0]      o_rsp_data;
  logic              o_rsp_ovr;

  int checks   = 0;
  int failures = 0;

  qmult_rr_sched #(.N(16), .Q(8), .NREQ(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_ovr   (o_rsp_ovr)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] b, input logic v);
    i_req_a[k*N +: N] = a;
    i_req_b[k*N +: N] = b;
    i_req_valid[k]    = v;
    #1;
  endtask

  // Present one operand pair, wait (bounded) for the grant, return just after the accepting edge.
  task automatic send(input int k, input logic [15:0] a, input logic [15:0] b);
    set_req(k, a, b, 1'b1);
    for (int n = 0; n < 20; n++) begin
      if (o_req_ready[k]) break;
      tick();
    end
    chk("grant", 32'(o_req_ready[k]), 32'd1);
    tick();
    i_req_valid[k] = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input int id, input logic [15:0] data, input logic ovr);
    chk({tag, "_valid"}, 32'(o_rsp_valid), 32'd1);
    chk({tag, "_id"},    32'(o_rsp_id),    32'(id));
    chk({tag, "_data"},  32'(o_rsp_data),  32'(data));
    chk({tag, "_ovr"},   32'(o_rsp_ovr),   32'(ovr));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst       = 1'b1;
    i_rsp_ready = 1'b1;
    i_req_valid = '0;
    i_req_a     = '0;
    i_req_b     = '0;
    tick();
    tick();
    chk("rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_id",    32'(o_rsp_id),    32'd0);
    chk("rst_data",  32'(o_rsp_data),  32'd0);
    chk("rst_ovr",   32'(o_rsp_ovr),   32'd0);
    chk("rst_ready", 32'(o_req_ready), 32'd0);
    i_rst = 1'b0;
    tick();

    // Basic products, one at a time
    send(0, 16'h0180, 16'h0200); tick(); expect_rsp("t1",  0, 16'h0300, 1'b0);
    send(1, 16'hFE80, 16'h0200); tick(); expect_rsp("t2a", 1, 16'hFD00, 1'b0);
    send(1, 16'hFF00, 16'hFF00); tick(); expect_rsp("t2b", 1, 16'h0100, 1'b0);
    send(2, 16'h4000, 16'h0400); tick(); expect_rsp("t3a", 2, OVP, 1'b1);
    send(3, 16'h8000, 16'h8000); tick(); expect_rsp("t3b", 3, OVP, 1'b1);
    send(3, 16'h8000, 16'h0100); tick(); expect_rsp("t3c", 3, OVN, 1'b1);
    send(0, 16'h7FFF, 16'h0100); tick(); expect_rsp("t3d", 0, 16'h7FFF, 1'b0);
    send(0, 16'h8001, 16'h0100); tick(); expect_rsp("t3e", 0, 16'h8001, 1'b0);
    tick();
    chk("t3_idle", 32'(o_rsp_valid), 32'd0);

    // All requesters continuously valid from reset
    i_rst = 1'b1; tick(); i_rst = 1'b0; tick();
    for (int k = 0; k < NREQ; k++) set_req(k, 16'((k + 1) << 8), 16'h0100, 1'b1);
    for (int c = 0; c < 8; c++) begin
      chk("t4_grant", 32'(o_req_ready), 32'(1 << (c % 4)));
      if (c >= 2) expect_rsp("t4", (c - 2) % 4, 16'(((c - 2) % 4 + 1) << 8), 1'b0);
      tick();
    end
    i_req_valid = '0;
    tick(); tick(); tick();
    chk("t4_idle", 32'(o_rsp_valid), 32'd0);

    // Backpressure: two entries held, third waits
    i_rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) set_req(k, 16'((k + 1) << 8), 16'h0100, 1'b1);
    chk("t5_g0", 32'(o_req_ready), 32'h1);
    tick(); i_req_valid[0] = 1'b0; #1;
    chk("t5_g1", 32'(o_req_ready), 32'h2);
    tick(); i_req_valid[1] = 1'b0; #1;
    for (int s = 0; s < 5; s++) begin
      chk("t5_stall_ready", 32'(o_req_ready), 32'h0);
      expect_rsp("t5_stall", 0, 16'h0100, 1'b0);
      tick();
    end
    i_rsp_ready = 1'b1; #1;
    chk("t5_g2", 32'(o_req_ready), 32'h4);
    expect_rsp("t5_r0", 0, 16'h0100, 1'b0);
    tick(); i_req_valid[2] = 1'b0;
    expect_rsp("t5_r1", 1, 16'h0200, 1'b0);
    tick();
    expect_rsp("t5_r2", 2, 16'h0300, 1'b0);
    tick();
    chk("t5_idle", 32'(o_rsp_valid), 32'd0);

    // Reset with both stages full
    i_rsp_ready = 1'b0;
    set_req(0, 16'h0100, 16'h0100, 1'b1);
    set_req(1, 16'h0200, 16'h0100, 1'b1);
    tick(); i_req_valid[0] = 1'b0;
    tick(); i_req_valid[1] = 1'b0;
    chk("t6_full", 32'(o_rsp_valid), 32'd1);
    i_rst = 1'b1; #1;
    chk("t6_rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("t6_rst_data",  32'(o_rsp_data),  32'd0);
    set_req(0, 16'h0500, 16'h0100, 1'b1);
    set_req(2, 16'h0600, 16'h0100, 1'b1);
    chk("t6_rst_ready", 32'(o_req_ready), 32'h0);
    i_rsp_ready = 1'b1;
    tick();
    i_rst = 1'b0; #1;
    chk("t6_first", 32'(o_req_ready), 32'h1);
    tick(); i_req_valid[0] = 1'b0; #1;
    chk("t6_second", 32'(o_req_ready), 32'h4);
    chk("t6_no_stale", 32'(o_rsp_valid), 32'd0);
    tick(); i_req_valid[2] = 1'b0;
    expect_rsp("t6_r0", 0, 16'h0500, 1'b0);
    tick();
    expect_rsp("t6_r2", 2, 16'h0600, 1'b0);
    tick();
    chk("t6_idle", 32'(o_rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
